ss_sg_mem_slave: RTL and testbench

- Wishbone slave that answers the scatter-gather engine's descriptor fetches and write-backs.
- Models descriptor memory as DEPTH 64-bit words addressed on 8-byte boundaries.
- Drives the 32-bit wbs_dat_o lane plus the wbs_dat64_o upper lane.
- Supports programmable wait states, CAB bursts, and out-of-range error response.
- Used as synthesizable descriptor store in SoC bring-up and as the responder in SG benches.

---
 rtl/ss_sg_pkg.sv | 31 +++
 rtl/ss_sg_mem_ram.sv | 36 +++
 rtl/ss_sg_mem_slave.sv | 169 ++++++++++++++++
 tb/tb_ss_sg_mem_slave.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_sg_pkg.sv
// Shared types for the scatter-gather descriptor store: slave FSM states,
// descriptor field positions within a stored word, and the Wishbone select width.
package ss_sg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BURST,
        S_ERR,
        S_RTY
    } state_e;

    localparam int WB_SEL_W = 4;

    // A descriptor is two 64-bit words; bit positions are within each 32-bit half.
    localparam int DESC_FLAGS_HI = 15;
    localparam int DESC_FLAGS_LO = 0;
    localparam int DESC_ADDR_HI  = 31;
    localparam int DESC_ADDR_LO  = 3;
    localparam int DESC_NEXT_HI  = 31;
    localparam int DESC_NEXT_LO  = 3;

    // Byte-lane mask for one 64-bit word: the same select drives both halves.
    function automatic logic [63:0] sel_to_mask(input logic [WB_SEL_W-1:0] sel);
        logic [31:0] half;
        half = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return {half, half};
    endfunction

endpackage

// File: rtl/ss_sg_mem_ram.sv
// Descriptor RAM: 2**AW x 64, asynchronous read, byte-enabled bus write port
// plus a full-word backdoor write port. The bus write wins a same-index collision.
module ss_sg_mem_ram
    import ss_sg_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic                clk,
    input  logic                bus_we,
    input  logic [AW-1:0]       bus_idx,
    input  logic [WB_SEL_W-1:0] bus_sel,
    input  logic [63:0]         bus_wdat,
    output logic [63:0]         bus_rdat,
    input  logic                ld_we,
    input  logic [AW-1:0]       ld_adr,
    input  logic [63:0]         ld_dat
);

    logic [63:0] mem [2**AW];
    logic [63:0] wmask;
    logic        ld_blocked;

    assign bus_rdat   = mem[bus_idx];
    assign wmask      = sel_to_mask(bus_sel);
    assign ld_blocked = bus_we && (ld_adr == bus_idx);

    always_ff @(posedge clk) begin
        if (ld_we && !ld_blocked) begin
            mem[ld_adr] <= ld_dat;
        end
        if (bus_we) begin
            mem[bus_idx] <= (mem[bus_idx] & ~wmask) | (bus_wdat & wmask);
        end
    end

endmodule

// File: rtl/ss_sg_mem_slave.sv
// Wishbone descriptor-memory slave with wait states, CAB bursts and error response.
// Define SS_SG_MEM_RTY_EN to add the rty_req port and RTY_N retry terminations.
module ss_sg_mem_slave
    import ss_sg_pkg::*;
#(
    parameter int          AW   = 6,
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int          WAIT = 1
`ifdef SS_SG_MEM_RTY_EN
   ,parameter int          RTY_N = 2
`endif
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                wbs_cyc,
    input  logic                wbs_stb,
    input  logic                wbs_we,
    input  logic                wbs_cab,
    input  logic [WB_SEL_W-1:0] wbs_sel,
    input  logic [31:0]         wbs_adr,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_dat64_i,
    output logic [31:0]         wbs_dat_o,
    output logic [31:0]         wbs_dat64_o,
    output logic                wbs_ack,
    output logic                wbs_err,
    output logic                wbs_rty,
`ifdef SS_SG_MEM_RTY_EN
    input  logic                rty_req,
`endif
    input  logic                ld_we,
    input  logic [AW-1:0]       ld_adr,
    input  logic [63:0]         ld_dat
);

    localparam logic [3:0] WAIT_M1 = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] dat_q, dat_d;
    logic        retry_q, retry_d;
    logic        retry_now;

    logic          req;
    logic          hit;
    logic [AW-1:0] idx;
    logic          burst_beat;
    logic          bus_wr;
    logic [63:0]   rd_word;
    logic          unused_adr;

    assign req        = wbs_cyc & wbs_stb;
    assign hit        = (wbs_adr[31:AW+3] == BASE[31:AW+3]);
    assign idx        = wbs_adr[AW+2:3];
    assign unused_adr = ^wbs_adr[2:0];

    // Burst beats terminate combinationally so the master can stream one word per clock.
    assign burst_beat = (state_q == S_BURST) & req & wbs_cab & hit;
    assign bus_wr     = wbs_we & (((state_q == S_ACK) & req) | burst_beat);

    ss_sg_mem_ram #(.AW(AW)) u_ram (
        .clk      (wb_clk_i),
        .bus_we   (bus_wr),
        .bus_idx  (idx),
        .bus_sel  (wbs_sel),
        .bus_wdat ({wbs_dat64_i, wbs_dat_i}),
        .bus_rdat (rd_word),
        .ld_we    (ld_we),
        .ld_adr   (ld_adr),
        .ld_dat   (ld_dat)
    );

`ifdef SS_SG_MEM_RTY_EN
    logic [7:0] rty_cnt_q, rty_cnt_d;

    // Once a retry sequence starts it runs to RTY_N regardless of rty_req.
    assign retry_now = (int'(rty_cnt_q) < RTY_N) && ((rty_cnt_q != 8'd0) || rty_req);

    always_comb begin
        rty_cnt_d = rty_cnt_q;
        if (state_q == S_ACK) begin
            rty_cnt_d = 8'd0;
        end else if (state_d == S_RTY) begin
            rty_cnt_d = rty_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rty_cnt_q <= 8'd0;
        end else begin
            rty_cnt_q <= rty_cnt_d;
        end
    end

    assign wbs_rty = (state_q == S_RTY) & wbs_cyc;
`else
    assign retry_now = 1'b0;
    assign wbs_rty   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        retry_d = retry_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!hit) begin
                        state_d = S_ERR;
                    end else begin
                        retry_d = retry_now;
                        if (WAIT == 0) begin
                            state_d = retry_now ? S_RTY : S_ACK;
                            if (!retry_now) dat_d = rd_word;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = WAIT_M1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = retry_q ? S_RTY : S_ACK;
                    if (!retry_q) dat_d = rd_word;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = (req & wbs_cab) ? S_BURST : S_IDLE;
            end
            S_BURST: begin
                if (!wbs_cyc || !wbs_cab) begin
                    state_d = S_IDLE;
                end else if (wbs_stb && !hit) begin
                    state_d = S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            dat_q   <= 64'd0;
            retry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            retry_q <= retry_d;
        end
    end

    assign wbs_ack     = ((state_q == S_ACK) & wbs_cyc) | burst_beat;
    assign wbs_err     = (state_q == S_ERR) & wbs_cyc;
    assign wbs_dat_o   = (state_q == S_BURST) ? rd_word[31:0]  : dat_q[31:0];
    assign wbs_dat64_o = (state_q == S_BURST) ? rd_word[63:32] : dat_q[63:32];

endmodule

// File: tb/tb_ss_sg_mem_slave.sv
// Scoreboard bench for ss_sg_mem_slave: a driver issues Wishbone cycles and queues
// expected terminations from a word-array model; a negedge monitor pops and compares.
module tb_ss_sg_mem_slave;

    localparam int          AW     = 6;
    localparam int          DEPTH  = 64;
    localparam int          WAIT_C = 1;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we, cab;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i, dat64_i;
    logic [31:0] dat_o, dat64_o;
    logic        ack, err, rty;
    logic        ld_we;
    logic [5:0]  ld_adr;
    logic [63:0] ld_dat;
`ifdef SS_SG_MEM_RTY_EN
    logic        rty_req;
`endif

    always #5 clk = ~clk;

    ss_sg_mem_slave #(.AW(AW), .BASE(BASE), .WAIT(WAIT_C)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wbs_cyc     (cyc),
        .wbs_stb     (stb),
        .wbs_we      (we),
        .wbs_cab     (cab),
        .wbs_sel     (sel),
        .wbs_adr     (adr),
        .wbs_dat_i   (dat_i),
        .wbs_dat64_i (dat64_i),
        .wbs_dat_o   (dat_o),
        .wbs_dat64_o (dat64_o),
        .wbs_ack     (ack),
        .wbs_err     (err),
        .wbs_rty     (rty),
`ifdef SS_SG_MEM_RTY_EN
        .rty_req     (rty_req),
`endif
        .ld_we       (ld_we),
        .ld_adr      (ld_adr),
        .ld_dat      (ld_dat)
    );

    // kind: 0 = ack, 1 = err, 2 = rty
    typedef struct {
        int          kind;
        bit          rd;
        logic [63:0] dat;
    } exp_t;

    exp_t        expq[$];
    logic [63:0] model [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [3:0] s);
        logic [63:0] r;
        r = old;
        if (s[0]) begin r[7:0]   = wd[7:0];   r[39:32] = wd[39:32]; end
        if (s[1]) begin r[15:8]  = wd[15:8];  r[47:40] = wd[47:40]; end
        if (s[2]) begin r[23:16] = wd[23:16]; r[55:48] = wd[55:48]; end
        if (s[3]) begin r[31:24] = wd[31:24]; r[63:56] = wd[63:56]; end
        return r;
    endfunction

    // Monitor: every termination must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        int   n;
        int   k;
        if (rst_n && (ack || err || rty)) begin
            n = int'(ack) + int'(err) + int'(rty);
            chk("term_onehot", 64'(n), 64'd1);
            chk("term_cyc", 64'(cyc), 64'd1);
            k = ack ? 0 : (err ? 1 : 2);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_term: got kind %0d expected none", k);
            end else begin
                e = expq.pop_front();
                chk("term_kind", 64'(k), 64'(e.kind));
                if (ack && e.rd && e.kind == 0) chk("rdata", {dat64_o, dat_o}, e.dat);
            end
        end
    end

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; cab = 1'b0; we = 1'b0;
    endtask

    task automatic wait_term(output int lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack || err || rty) begin
                ok  = 1'b1;
                lat = c;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no termination expected one within 40 cycles");
        end
    endtask

    task automatic load(input int ix, input logic [63:0] d);
        @(posedge clk); #1;
        ld_we = 1'b1; ld_adr = 6'(ix); ld_dat = d;
        model[ix] = d;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic single(input bit wr, input logic [31:0] a, input logic [3:0] s,
                          input logic [63:0] wd, input bit exp_rty);
        exp_t e;
        int   lat;
        bit   ok;
        bit   inwin;
        int   widx;
        inwin  = (a >= BASE) && ((a - BASE) < 32'(DEPTH * 8));
        widx   = int'((a - BASE) >> 3);
        e.kind = !inwin ? 1 : (exp_rty ? 2 : 0);
        e.rd   = !wr;
        e.dat  = inwin ? model[widx] : 64'd0;
        expq.push_back(e);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; cab = 1'b0; we = wr; adr = a; sel = s;
        dat_i = wd[31:0]; dat64_i = wd[63:32];
        wait_term(lat, ok);
        if (ok) chk(inwin ? "lat_single" : "lat_err", 64'(lat), inwin ? 64'(WAIT_C + 1) : 64'd1);
        if (inwin && wr && !exp_rty) model[widx] = merge(model[widx], wd, s);
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic burst(input bit wr, input int idx0, input int n, input logic [3:0] s);
        exp_t        e;
        int          lat;
        bit          ok;
        bit          inwin;
        int          ix;
        logic [63:0] wd;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ix     = idx0 + i;
            inwin  = ix < DEPTH;
            wd     = {$urandom, $urandom};
            e.kind = inwin ? 0 : 1;
            e.rd   = !wr;
            e.dat  = inwin ? model[ix] : 64'd0;
            expq.push_back(e);
            cyc = 1'b1; stb = 1'b1; cab = 1'b1; we = wr; sel = s;
            adr = BASE + 32'(ix * 8); dat_i = wd[31:0]; dat64_i = wd[63:32];
            wait_term(lat, ok);
            if (ok) chk("lat_burst", 64'(lat),
                        (i == 0) ? (inwin ? 64'(WAIT_C + 1) : 64'd1) : (inwin ? 64'd0 : 64'd1));
            if (inwin && wr) model[ix] = merge(model[ix], wd, s);
            if (!ok || !inwin) break;
        end
        @(posedge clk); #1;
        idle_bus();
    endtask

    initial begin
        int          r;
        int          ix;
        logic [63:0] wd;
        rst_n = 1'b0;
        idle_bus();
        sel = 4'hF; adr = 32'd0; dat_i = 32'd0; dat64_i = 32'd0;
        ld_we = 1'b0; ld_adr = 6'd0; ld_dat = 64'd0;
`ifdef SS_SG_MEM_RTY_EN
        rty_req = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rty", 64'(rty), 64'd0);
        chk("rst_dat", {dat64_o, dat_o}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) load(i, {$urandom, $urandom});

        // Backdoor preload then single read with wait states.
        load(3, 64'h1122_3344_5566_7788);
        single(1'b0, 32'h18, 4'hF, 64'd0, 1'b0);

        // Partial-lane write over a zeroed word, then readback.
        load(4, 64'd0);
        single(1'b1, 32'h20, 4'b0011, 64'hCCCC_DDDD_AAAA_BBBB, 1'b0);
        chk("model_sel_write", model[4], 64'h0000_DDDD_0000_BBBB);
        single(1'b0, 32'h20, 4'hF, 64'd0, 1'b0);

        // CAB read burst of four.
        for (int i = 0; i < 4; i++) load(i, 64'(i));
        burst(1'b0, 0, 4, 4'hF);

        // Out-of-window single, then a burst running off the window end.
        single(1'b0, BASE + 32'(DEPTH * 8), 4'hF, 64'd0, 1'b0);
        single(1'b1, BASE + 32'(DEPTH * 8) + 32'h8, 4'hF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        burst(1'b0, DEPTH - 2, 4, 4'hF);

        // Reset during the wait state of a write: no ack, word untouched.
        load(5, 64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h28; sel = 4'hF;
        dat_i = 32'hFFFF_FFFF; dat64_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 64'(ack), 64'd0);
        chk("midrst_dat", {dat64_o, dat_o}, 64'd0);
        idle_bus();
        @(posedge clk); #1;
        rst_n = 1'b1;
        single(1'b0, 32'h28, 4'hF, 64'd0, 1'b0);

`ifdef SS_SG_MEM_RTY_EN
        rty_req = 1'b1;
        single(1'b0, 32'h18, 4'hF, 64'd0, 1'b1);
        single(1'b0, 32'h18, 4'hF, 64'd0, 1'b1);
        single(1'b0, 32'h18, 4'hF, 64'd0, 1'b0);
        rty_req = 1'b0;
`endif

        // Randomized mix of singles, misses, bursts and backdoor loads.
        for (int t = 0; t < 80; t++) begin
            r  = $urandom_range(0, 11);
            ix = $urandom_range(0, DEPTH - 1);
            wd = {$urandom, $urandom};
            if (r <= 3) begin
                single(1'b0, BASE + 32'(ix * 8) + 32'($urandom_range(0, 7)), 4'hF, 64'd0, 1'b0);
            end else if (r <= 6) begin
                single(1'b1, BASE + 32'(ix * 8), 4'($urandom_range(0, 15)), wd, 1'b0);
            end else if (r == 7) begin
                single($urandom_range(0, 1) == 1, 32'h0000_0200 | ($urandom & 32'hFFFF_FFF8),
                       4'hF, wd, 1'b0);
            end else if (r <= 10) begin
                burst($urandom_range(0, 1) == 1, ix, $urandom_range(1, 5), 4'($urandom_range(0, 15)));
            end else begin
                load(ix, wd);
            end
        end

        repeat (4) @(posedge clk);
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
